// File: rtl/vsb_chan_requester.sv
// Per-channel write requester for the VSB round-robin arbiter.
// Local writes are queued in a small FIFO; the head entry is presented to the
// arbiter with rqst raised and is retired on each one-cycle ack pulse.
module vsb_chan_requester #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     rqst,
  input  logic                     ack,
  output logic [ADDR_W-1:0]        vsbaddr,
  output logic [DATA_W-1:0]        vsbdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     spurious_ack
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          spur_q, spur_d;

  logic push, pop, empty;

  // Ready depends only on the registered count, so ack never reaches wr_ready
  // combinationally; a full FIFO therefore refuses a push even in an ack cycle.
  assign empty    = (cnt_q == '0);
  assign wr_ready = (cnt_q < FULL_CNT);
  assign push     = wr_valid && wr_ready;
  assign pop      = ack && !empty;

  // The arbiter samples rqst a cycle ahead of its ack, so rqst must fall during
  // the ack of the last entry or a phantom entry would be granted.
  assign rqst = !empty && !(ack && (cnt_q == ONE_CNT));

  // Head entry stays stable through the ack cycle; the pop lands on the edge
  // that ends it. Outputs are forced to zero while nothing is queued.
  assign vsbaddr      = empty ? '0 : addr_mem_q[rd_ptr_q];
  assign vsbdata      = empty ? '0 : data_mem_q[rd_ptr_q];
  assign level        = cnt_q;
  assign spurious_ack = spur_q;

  // Next-state for pointers, occupancy and the sticky spurious-ack flag.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    spur_d   = spur_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + ONE_CNT;
      2'b01:   cnt_d = cnt_q - ONE_CNT;
      default: cnt_d = cnt_q;
    endcase
    if (ack && empty) spur_d = 1'b1;
  end

  // Control state with asynchronous active-low reset; reset discards the queue.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      spur_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      spur_q   <= spur_d;
    end
  end

  // Entry storage needs no reset: unoccupied slots are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= wr_addr;
      data_mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_vsb_chan_requester.sv
// Self-checking bench for vsb_chan_requester: directed scenarios plus a
// scoreboard monitor that tracks queued entries and checks every ack capture.
module tb_vsb_chan_requester;

  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int LW    = 3;

  logic          clk;
  logic          nreset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rqst;
  logic          ack;
  logic [AW-1:0] vsbaddr;
  logic [DW-1:0] vsbdata;
  logic [LW-1:0] level;
  logic          spurious_ack;

  vsb_chan_requester #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rqst         (rqst),
    .ack          (ack),
    .vsbaddr      (vsbaddr),
    .vsbdata      (vsbdata),
    .level        (level),
    .spurious_ack (spurious_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_checks;
  int                n_fails;
  logic [AW+DW-1:0]  exp_q [$];
  logic              exp_spur;
  int                sz;
  logic              exp_rdy;
  logic              exp_rq;

  // Inputs change on the falling edge; the DUT captures them on the next rise.
  task automatic drive(input logic v, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic k);
    @(negedge clk);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    ack      = k;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (rqst !== 1'b0 || level !== 3'd0 || wr_ready !== 1'b1 ||
        vsbaddr !== 8'h00 || vsbdata !== 16'h0000 || spurious_ack !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_state: rqst=%b level=%0d wr_ready=%b addr=%h data=%h spur=%b, expected 0/0/1/00/0000/0",
               rqst, level, wr_ready, vsbaddr, vsbdata, spurious_ack);
    end
    @(negedge clk);
    nreset = 1'b1;
    drive(1'b1, 8'h01, 16'h1111, 1'b0);
    drive(1'b1, 8'h02, 16'h2222, 1'b0);
    drive(1'b1, 8'h03, 16'h3333, 1'b0);
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    @(negedge clk);
    #2;
    nreset = 1'b0;
    exp_q.delete();
    exp_spur = 1'b0;
    #1;
    n_checks++;
    if (rqst !== 1'b0 || level !== 3'd0 || wr_ready !== 1'b1 ||
        vsbaddr !== 8'h00 || vsbdata !== 16'h0000) begin
      n_fails++;
      $display("FAIL reset_midstream: rqst=%b level=%0d wr_ready=%b addr=%h data=%h, expected 0/0/1/00/0000",
               rqst, level, wr_ready, vsbaddr, vsbdata);
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 16'h0000, 1'b0);
      #1;
      n_checks++;
      if (rqst !== 1'b0 || level !== 3'd0) begin
        n_fails++;
        $display("FAIL post_reset_idle: rqst=%b level=%0d, expected 0/0", rqst, level);
      end
    end
  endtask

  task automatic test_single_write();
    drive(1'b1, 8'h12, 16'h3456, 1'b0);
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #1;
    n_checks++;
    if (rqst !== 1'b1 || vsbaddr !== 8'h12 || vsbdata !== 16'h3456) begin
      n_fails++;
      $display("FAIL single_present: rqst=%b addr=%h data=%h, expected 1/12/3456", rqst, vsbaddr, vsbdata);
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    #1;
    n_checks++;
    if (rqst !== 1'b0) begin
      n_fails++;
      $display("FAIL single_rqst_drop: rqst=%b, expected 0", rqst);
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #1;
    n_checks++;
    if (level !== 3'd0) begin
      n_fails++;
      $display("FAIL single_level: level=%0d, expected 0", level);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 8'(8'hA0 + i), 16'(16'h1000 + i), 1'b0);
    drive(1'b1, 8'hA5, 16'h5555, 1'b0);
    #1;
    n_checks++;
    if (wr_ready !== 1'b0 || level !== 3'd4) begin
      n_fails++;
      $display("FAIL fill_full: wr_ready=%b level=%0d, expected 0/4", wr_ready, level);
    end
    drive(1'b1, 8'hA5, 16'h5555, 1'b1);
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL full_ack_ready: wr_ready=%b, expected 0", wr_ready);
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    #1;
    n_checks++;
    if (wr_ready !== 1'b1 || level !== 3'd3) begin
      n_fails++;
      $display("FAIL ready_return: wr_ready=%b level=%0d, expected 1/3", wr_ready, level);
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    #1;
    n_checks++;
    if (rqst !== 1'b0 || vsbaddr !== 8'hA3 || vsbdata !== 16'h1003) begin
      n_fails++;
      $display("FAIL drain_last: rqst=%b addr=%h data=%h, expected 0/A3/1003", rqst, vsbaddr, vsbdata);
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #1;
    n_checks++;
    if (level !== 3'd0) begin
      n_fails++;
      $display("FAIL drain_level: level=%0d, expected 0", level);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 8'hB0, 16'hB000, 1'b0);
    drive(1'b1, 8'hB1, 16'hB111, 1'b0);
    drive(1'b1, 8'hB2, 16'hB222, 1'b1);
    #1;
    n_checks++;
    if (level !== 3'd2 || vsbaddr !== 8'hB0) begin
      n_fails++;
      $display("FAIL simul_before: level=%0d addr=%h, expected 2/B0", level, vsbaddr);
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #1;
    n_checks++;
    if (level !== 3'd2 || vsbaddr !== 8'hB1 || vsbdata !== 16'hB111) begin
      n_fails++;
      $display("FAIL simul_after: level=%0d addr=%h data=%h, expected 2/B1/B111", level, vsbaddr, vsbdata);
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    #1;
    n_checks++;
    if (rqst !== 1'b0 || vsbaddr !== 8'hB2 || vsbdata !== 16'hB222) begin
      n_fails++;
      $display("FAIL simul_tail: rqst=%b addr=%h data=%h, expected 0/B2/B222", rqst, vsbaddr, vsbdata);
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
  endtask

  task automatic test_handoff();
    drive(1'b1, 8'hC0, 16'hC000, 1'b0);
    drive(1'b1, 8'hC1, 16'hC111, 1'b1);
    #1;
    n_checks++;
    if (rqst !== 1'b0 || vsbaddr !== 8'hC0) begin
      n_fails++;
      $display("FAIL handoff_ack_cycle: rqst=%b addr=%h, expected 0/C0", rqst, vsbaddr);
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #1;
    n_checks++;
    if (rqst !== 1'b1 || vsbaddr !== 8'hC1 || vsbdata !== 16'hC111 || level !== 3'd1) begin
      n_fails++;
      $display("FAIL handoff_next: rqst=%b addr=%h data=%h level=%0d, expected 1/C1/C111/1",
               rqst, vsbaddr, vsbdata, level);
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #1;
    n_checks++;
    if (level !== 3'd0) begin
      n_fails++;
      $display("FAIL handoff_level: level=%0d, expected 0", level);
    end
  endtask

  task automatic test_back_to_back();
    logic v, k;
    for (int i = 0; i < 80; i++) begin
      v = 1'($urandom_range(0, 1));
      k = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      drive(v, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), k);
    end
    for (int i = 0; i < 3 * DEPTH && exp_q.size() > 0; i++)
      drive(1'b0, 8'h00, 16'h0000, 1'b1);
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #1;
    n_checks++;
    if (level !== 3'd0 || exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL random_drain: level=%0d pending=%0d, expected 0/0", level, exp_q.size());
    end
  endtask

  task automatic test_spurious();
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #1;
    n_checks++;
    if (spurious_ack !== 1'b1 || level !== 3'd0 || rqst !== 1'b0) begin
      n_fails++;
      $display("FAIL spurious_set: spur=%b level=%0d rqst=%b, expected 1/0/0", spurious_ack, level, rqst);
    end
    drive(1'b1, 8'hD0, 16'hD000, 1'b0);
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #1;
    n_checks++;
    if (spurious_ack !== 1'b1 || level !== 3'd0) begin
      n_fails++;
      $display("FAIL spurious_sticky: spur=%b level=%0d, expected 1/0", spurious_ack, level);
    end
    @(negedge clk);
    nreset = 1'b0;
    exp_spur = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if (spurious_ack !== 1'b0) begin
      n_fails++;
      $display("FAIL spurious_clear: spur=%b, expected 0", spurious_ack);
    end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_spur = 1'b0;
    nreset   = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    ack      = 1'b0;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          #4;
          if (nreset) begin
            sz      = exp_q.size();
            exp_rdy = (sz < DEPTH);
            exp_rq  = (sz > 0) && !(ack && sz == 1);
            n_checks++;
            if (wr_ready !== exp_rdy || rqst !== exp_rq || level !== LW'(sz) ||
                spurious_ack !== exp_spur) begin
              n_fails++;
              $display("FAIL monitor_state @%0t: wr_ready=%b rqst=%b level=%0d spur=%b, expected %b/%b/%0d/%b",
                       $time, wr_ready, rqst, level, spurious_ack, exp_rdy, exp_rq, sz, exp_spur);
            end
            if (sz == 0) begin
              n_checks++;
              if (vsbaddr !== 8'h00 || vsbdata !== 16'h0000) begin
                n_fails++;
                $display("FAIL empty_outputs @%0t: addr=%h data=%h, expected 00/0000", $time, vsbaddr, vsbdata);
              end
            end
            if (ack) begin
              if (sz > 0) begin
                n_checks++;
                if ({vsbaddr, vsbdata} !== exp_q[0]) begin
                  n_fails++;
                  $display("FAIL ack_capture @%0t: got %h/%h, expected %h/%h", $time,
                           vsbaddr, vsbdata, exp_q[0][AW+DW-1:DW], exp_q[0][DW-1:0]);
                end
                void'(exp_q.pop_front());
              end else begin
                exp_spur = 1'b1;
              end
            end
            if (wr_valid && exp_rdy) exp_q.push_back({wr_addr, wr_data});
          end
        end
      end
    join_none
    test_reset();
    test_single_write();
    test_fill_drain();
    test_simultaneous();
    test_handoff();
    test_back_to_back();
    test_spurious();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
